rst_seq: RTL and testbench

RST_SEQ -- requirements
Module: rst_seq

---
 rtl/rst_seq_pkg.sv | 20 ++
 rtl/rst_sync.sv | 34 +++
 rtl/rst_seq.sv | 137 +++++++++++++
 tb/tb_rst_seq.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// Shared types and legal-range constants for the rst_seq reset sequencer.
// Used by rst_seq and rst_sync.
package rst_seq_pkg;

  localparam int unsigned N_STAGES_MAX    = 8;
  localparam int unsigned SYNC_STAGES_MIN = 2;
  localparam int unsigned STAGE_IDX_W     = $clog2(N_STAGES_MAX);

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_STAGE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage : rst_seq_pkg

// File: rtl/rst_sync.sv
// Reset synchronizer: asynchronous assert, synchronous deassert through
// SYNC_STAGES flops. o_release_c flags the edge on which o_rst_n goes high.
module rst_sync
  import rst_seq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_async_rst_n,
  output logic o_rst_n,
  output logic o_release_c
);

  if (SYNC_STAGES < SYNC_STAGES_MIN) begin : g_bad_sync_stages
    $fatal(1, "rst_sync: SYNC_STAGES must be >= %0d", SYNC_STAGES_MIN);
  end

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_async_rst_n) begin
    if (!i_async_rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign o_rst_n = r_sync[SYNC_STAGES-1];

  // High when the last flop is about to capture 1, so the sequencer can leave
  // reset on the same edge the synchronized release appears.
  assign o_release_c = r_sync[SYNC_STAGES-2] & ~r_sync[SYNC_STAGES-1];

endmodule : rst_sync

// File: rtl/rst_seq.sv
// Staged reset sequencer: synchronizes the async reset release, then frees
// o_sync_rst bits in ascending order. Optional soft reset: RST_SEQ_SOFT_RST_EN.
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int unsigned N_STAGES    = 2,
  parameter int unsigned HOLD_CYCLES = 2,
  parameter int unsigned STAGE_GAP   = 1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                i_clk,
  input  logic                i_async_rst_n,
  input  logic                i_soft_rst_req,
  output logic [N_STAGES-1:0] o_sync_rst,
  output logic                o_rst_done
);

  if (N_STAGES < 1 || N_STAGES > N_STAGES_MAX) begin : g_bad_n_stages
    $fatal(1, "rst_seq: N_STAGES must be 1..%0d", N_STAGES_MAX);
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $fatal(1, "rst_seq: HOLD_CYCLES must be >= 1");
  end
  if (STAGE_GAP < 1) begin : g_bad_gap
    $fatal(1, "rst_seq: STAGE_GAP must be >= 1");
  end
  if (SYNC_STAGES < SYNC_STAGES_MIN) begin : g_bad_sync
    $fatal(1, "rst_seq: SYNC_STAGES must be >= %0d", SYNC_STAGES_MIN);
  end

  localparam int unsigned CNT_W = $clog2(max_u(HOLD_CYCLES, STAGE_GAP) + 1);

  localparam logic [CNT_W-1:0]       HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]       GAP_LOAD   = CNT_W'(STAGE_GAP - 1);
  localparam logic [STAGE_IDX_W-1:0] LAST_STAGE = STAGE_IDX_W'(N_STAGES - 1);

  logic                   w_sync_rst_n;
  logic                   w_release_c;
  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [STAGE_IDX_W-1:0] r_stage;
  logic [N_STAGES-1:0]    r_sync_rst;
  logic                   r_rst_done;

  rst_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_rst_sync (
    .i_clk         (i_clk),
    .i_async_rst_n (i_async_rst_n),
    .o_rst_n       (w_sync_rst_n),
    .o_release_c   (w_release_c)
  );

`ifndef RST_SEQ_SOFT_RST_EN
  logic w_unused_soft;
  assign w_unused_soft = i_soft_rst_req;
`endif

  // Sequencer: stages release by shifting a zero in from bit 0, which keeps
  // the release order strictly ascending and released bits low.
  always_ff @(posedge i_clk or negedge i_async_rst_n) begin
    if (!i_async_rst_n) begin
      r_state    <= ST_RST;
      r_cnt      <= '0;
      r_stage    <= '0;
      r_sync_rst <= '1;
      r_rst_done <= 1'b0;
    end else begin
      case (r_state)
        ST_RST: begin
          if (w_release_c || w_sync_rst_n) begin
            r_state <= ST_HOLD;
            r_cnt   <= HOLD_LOAD;
          end
        end

        ST_HOLD: begin
          if (r_cnt == '0) begin
            r_sync_rst <= r_sync_rst << 1;
            r_cnt      <= GAP_LOAD;
            r_stage    <= STAGE_IDX_W'(1);
            if (N_STAGES == 1) begin
              r_state    <= ST_DONE;
              r_rst_done <= 1'b1;
            end else begin
              r_state <= ST_STAGE;
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end

        ST_STAGE: begin
          if (r_cnt == '0) begin
            r_sync_rst <= r_sync_rst << 1;
            r_cnt      <= GAP_LOAD;
            r_stage    <= r_stage + STAGE_IDX_W'(1);
            if (r_stage == LAST_STAGE) begin
              r_state    <= ST_DONE;
              r_rst_done <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end

        ST_DONE: begin
`ifdef RST_SEQ_SOFT_RST_EN
          // Soft reset re-enters the hold phase directly; the synchronizer
          // is already released and stays that way.
          if (i_soft_rst_req) begin
            r_state    <= ST_HOLD;
            r_cnt      <= HOLD_LOAD;
            r_stage    <= '0;
            r_sync_rst <= '1;
            r_rst_done <= 1'b0;
          end
`else
          r_state <= ST_DONE;
`endif
        end

        default: begin
          r_state    <= ST_RST;
          r_cnt      <= '0;
          r_stage    <= '0;
          r_sync_rst <= '1;
          r_rst_done <= 1'b0;
        end
      endcase
    end
  end

  assign o_sync_rst = r_sync_rst;
  assign o_rst_done = r_rst_done;

endmodule : rst_seq

// File: tb/tb_rst_seq.sv
// Directed bench for rst_seq: four instances (defaults, 3-stage, 1-stage,
// soft request held high) checked against a per-edge expectation table.
module tb_rst_seq;

`ifdef RST_SEQ_SOFT_RST_EN
  localparam bit SOFT_EN = 1'b1;
`else
  localparam bit SOFT_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       soft_req;
  logic       soft_zero;
  logic       soft_hold;
  logic [1:0] def_rst;
  logic       def_done;
  logic [2:0] b_rst;
  logic       b_done;
  logic [0:0] c_rst;
  logic       c_done;
  logic [1:0] h_rst;
  logic       h_done;

  int unsigned n_checks;
  int unsigned n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  rst_seq dut_def (
    .i_clk          (clk),
    .i_async_rst_n  (rst_n),
    .i_soft_rst_req (soft_req),
    .o_sync_rst     (def_rst),
    .o_rst_done     (def_done)
  );

  rst_seq #(
    .N_STAGES    (3),
    .HOLD_CYCLES (3),
    .STAGE_GAP   (2),
    .SYNC_STAGES (2)
  ) dut_b (
    .i_clk          (clk),
    .i_async_rst_n  (rst_n),
    .i_soft_rst_req (soft_zero),
    .o_sync_rst     (b_rst),
    .o_rst_done     (b_done)
  );

  rst_seq #(
    .N_STAGES    (1),
    .HOLD_CYCLES (2),
    .STAGE_GAP   (1),
    .SYNC_STAGES (2)
  ) dut_c (
    .i_clk          (clk),
    .i_async_rst_n  (rst_n),
    .i_soft_rst_req (soft_zero),
    .o_sync_rst     (c_rst),
    .o_rst_done     (c_done)
  );

  rst_seq dut_h (
    .i_clk          (clk),
    .i_async_rst_n  (rst_n),
    .i_soft_rst_req (soft_hold),
    .o_sync_rst     (h_rst),
    .o_rst_done     (h_done)
  );

  typedef struct {
    int unsigned edge_n;
    logic [1:0]  def_rst;
    logic        def_done;
    logic [2:0]  b_rst;
    logic        b_done;
    logic        c_rst;
    logic        c_done;
    logic [1:0]  h_rst;
    logic        h_done;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_reset(input string tag);
    chk({tag, " def_rst"},  8'(def_rst),  8'h03);
    chk({tag, " def_done"}, 8'(def_done), 8'h00);
    chk({tag, " b_rst"},    8'(b_rst),    8'h07);
    chk({tag, " b_done"},   8'(b_done),   8'h00);
    chk({tag, " c_rst"},    8'(c_rst),    8'h01);
    chk({tag, " c_done"},   8'(c_done),   8'h00);
    chk({tag, " h_rst"},    8'(h_rst),    8'h03);
    chk({tag, " h_done"},   8'(h_done),   8'h00);
  endtask

  // Edges are counted from the first rising edge after a mid-cycle deassert.
  task automatic run_table(input int pass);
    logic [1:0] hx;
    logic       hd;
    for (int i = 0; i < 13; i++) begin
      step();
      hx = (pass == 1 && SOFT_EN) ? vecs[i].h_rst  : vecs[i].def_rst;
      hd = (pass == 1 && SOFT_EN) ? vecs[i].h_done : vecs[i].def_done;
      chk($sformatf("p%0d e%0d def_rst",  pass, vecs[i].edge_n), 8'(def_rst),  8'(vecs[i].def_rst));
      chk($sformatf("p%0d e%0d def_done", pass, vecs[i].edge_n), 8'(def_done), 8'(vecs[i].def_done));
      chk($sformatf("p%0d e%0d b_rst",    pass, vecs[i].edge_n), 8'(b_rst),    8'(vecs[i].b_rst));
      chk($sformatf("p%0d e%0d b_done",   pass, vecs[i].edge_n), 8'(b_done),   8'(vecs[i].b_done));
      chk($sformatf("p%0d e%0d c_rst",    pass, vecs[i].edge_n), 8'(c_rst),    8'(vecs[i].c_rst));
      chk($sformatf("p%0d e%0d c_done",   pass, vecs[i].edge_n), 8'(c_done),   8'(vecs[i].c_done));
      chk($sformatf("p%0d e%0d h_rst",    pass, vecs[i].edge_n), 8'(h_rst),    8'(hx));
      chk($sformatf("p%0d e%0d h_done",   pass, vecs[i].edge_n), 8'(h_done),   8'(hd));
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    //          edge def   dd    b       bd    c     cd    h(soft) hd
    vecs[0]  = '{ 1, 2'b11, 1'b0, 3'b111, 1'b0, 1'b1, 1'b0, 2'b11, 1'b0};
    vecs[1]  = '{ 2, 2'b11, 1'b0, 3'b111, 1'b0, 1'b1, 1'b0, 2'b11, 1'b0};
    vecs[2]  = '{ 3, 2'b11, 1'b0, 3'b111, 1'b0, 1'b1, 1'b0, 2'b11, 1'b0};
    vecs[3]  = '{ 4, 2'b10, 1'b0, 3'b111, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0};
    vecs[4]  = '{ 5, 2'b00, 1'b1, 3'b110, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1};
    vecs[5]  = '{ 6, 2'b00, 1'b1, 3'b110, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0};
    vecs[6]  = '{ 7, 2'b00, 1'b1, 3'b100, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0};
    vecs[7]  = '{ 8, 2'b00, 1'b1, 3'b100, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0};
    vecs[8]  = '{ 9, 2'b00, 1'b1, 3'b000, 1'b1, 1'b0, 1'b1, 2'b00, 1'b1};
    vecs[9]  = '{10, 2'b00, 1'b1, 3'b000, 1'b1, 1'b0, 1'b1, 2'b11, 1'b0};
    vecs[10] = '{11, 2'b00, 1'b1, 3'b000, 1'b1, 1'b0, 1'b1, 2'b11, 1'b0};
    vecs[11] = '{12, 2'b00, 1'b1, 3'b000, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0};
    vecs[12] = '{13, 2'b00, 1'b1, 3'b000, 1'b1, 1'b0, 1'b1, 2'b00, 1'b1};

    rst_n     = 1'b0;
    soft_req  = 1'b0;
    soft_zero = 1'b0;
    soft_hold = 1'b1;

    repeat (3) step();
    chk_all_reset("reset");

    // Deassert between edges, soft request on dut_h held high from time 0.
    #2 rst_n = 1'b1;
    run_table(1);
    soft_hold = 1'b0;

    // Single-cycle soft request on the default instance while in ST_DONE.
    soft_req = 1'b1;
    step();
    soft_req = 1'b0;
    chk("soft e14 def_rst",  8'(def_rst),  SOFT_EN ? 8'h03 : 8'h00);
    chk("soft e14 def_done", 8'(def_done), SOFT_EN ? 8'h00 : 8'h01);
    chk("soft e14 h_rst",    8'(h_rst),    8'h00);
    chk("soft e14 h_done",   8'(h_done),   8'h01);
    step();
    chk("soft e15 def_rst",  8'(def_rst),  SOFT_EN ? 8'h03 : 8'h00);
    chk("soft e15 def_done", 8'(def_done), SOFT_EN ? 8'h00 : 8'h01);
    step();
    chk("soft e16 def_rst",  8'(def_rst),  SOFT_EN ? 8'h02 : 8'h00);
    chk("soft e16 def_done", 8'(def_done), SOFT_EN ? 8'h00 : 8'h01);
    step();
    chk("soft e17 def_rst",  8'(def_rst),  8'h00);
    chk("soft e17 def_done", 8'(def_done), 8'h01);

    // Async assert mid-cycle takes effect without a clock edge.
    #1 rst_n = 1'b0;
    #1 chk_all_reset("assert");
    step();
    step();
    #2 rst_n = 1'b1;
    repeat (4) step();
    chk("pre-abort def_rst", 8'(def_rst), 8'h02);
    chk("pre-abort c_done",  8'(c_done),  8'h01);
    rst_n = 1'b0;
    #1 chk_all_reset("abort");
    step();
    chk_all_reset("abort held");
    #2 rst_n = 1'b1;
    run_table(2);

    // Short glitch inside one clock period still resets everything.
    #2 rst_n = 1'b0;
    #1 chk_all_reset("glitch");
    #2 rst_n = 1'b1;
    run_table(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_rst_seq
